// File: rtl/bcci_axis_frame_source.sv
// AXI-Stream frame source: reads a W x H image in raster order from a synchronous-read
// memory and streams it out with SOF on m_axis_user and end-of-line on m_axis_tlast.
module bcci_axis_frame_source #(
   parameter int AXIS_DATA_WIDTH = 24,
   parameter int SRC_IMG_WIDTH   = 960,
   parameter int SRC_IMG_HEIGHT  = 540,
   parameter int MEM_ADDR_WIDTH  = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0]    mem_rd_addr,
   input  logic [AXIS_DATA_WIDTH-1:0]   mem_rd_data,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tid,
   output logic                         m_axis_tdest,
   output logic                         m_axis_user
);

   localparam int COL_W = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
   localparam int ROW_W = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
   localparam int KW    = AXIS_DATA_WIDTH / 8;
   localparam int EW    = AXIS_DATA_WIDTH + 2;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;
   logic                      r_inflight;
   logic                      r_pend_last;
   logic                      r_pend_user;
   logic [EW-1:0]             r_fifo [2];
   logic                      r_wr_ptr;
   logic                      r_rd_ptr;
   logic [1:0]                r_count;

   logic                      w_rd_en;
   logic                      w_valid;
   logic                      w_pop;
   logic                      w_push;
   logic                      w_col_last;
   logic                      w_issue_last;
   logic [2:0]                w_occ;
   logic [EW-1:0]             w_head;

   assign w_valid      = (r_count != 2'd0);
   assign w_pop        = w_valid && m_axis_tready;
   assign w_push       = r_inflight;
   assign w_col_last   = (r_col == COL_LAST);
   assign w_issue_last = w_col_last && (r_row == ROW_LAST);
   // Occupancy net of this cycle's pop, so a full-rate stream keeps one read in flight.
   assign w_occ        = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};

   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_FETCH;
         end
         S_FETCH: begin
            if (w_occ < 3'd2) begin
               w_rd_en = 1'b1;
               if (w_issue_last) w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Every read is issued: the last pending entry leaving means the frame is out.
            if (w_pop && (r_count == 2'd1) && !r_inflight) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_state_next = start ? S_FETCH : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_inflight  <= 1'b0;
         r_pend_last <= 1'b0;
         r_pend_user <= 1'b0;
         r_fifo[0]   <= '0;
         r_fifo[1]   <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= w_rd_en;
         if (w_rd_en) begin
            r_pend_last <= w_col_last;
            r_pend_user <= (r_addr == '0);
            if (w_issue_last) begin
               r_addr <= '0;
               r_col  <= '0;
               r_row  <= '0;
            end else begin
               r_addr <= r_addr + MEM_ADDR_WIDTH'(1);
               if (w_col_last) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
         end
         if (w_push) begin
            r_fifo[r_wr_ptr] <= {mem_rd_data, r_pend_last, r_pend_user};
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign w_head        = r_fifo[r_rd_ptr] & {EW{w_valid}};
   assign m_axis_tvalid = w_valid;
   assign m_axis_tdata  = w_head[EW-1:2];
   assign m_axis_tlast  = w_head[1];
   assign m_axis_user   = w_head[0];
   assign m_axis_tkeep  = {KW{w_valid}};
   assign m_axis_tstrb  = {KW{w_valid}};
   assign m_axis_tid    = 1'b0;
   assign m_axis_tdest  = 1'b0;
   assign mem_rd_en     = w_rd_en;
   assign mem_rd_addr   = r_addr;
   assign busy          = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_bcci_axis_frame_source.sv
// Bench for bcci_axis_frame_source: a 4x2 instance and a 1x3 instance, scoreboard queues
// filled by the stimulus and drained by negedge monitors on each stream handshake.
module tb_bcci_axis_frame_source;

   localparam int DW = 24;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4x2 instance
   logic          a_rst_n, a_start, a_busy, a_done, a_rd_en;
   logic [19:0]   a_rd_addr;
   logic [DW-1:0] a_rd_data;
   logic          a_tvalid, a_tready, a_tlast, a_tid, a_tdest, a_user;
   logic [DW-1:0] a_tdata;
   logic [2:0]    a_tkeep, a_tstrb;

   // 1x3 instance
   logic          b_rst_n, b_start, b_busy, b_done, b_rd_en;
   logic [1:0]    b_rd_addr;
   logic [DW-1:0] b_rd_data;
   logic          b_tvalid, b_tready, b_tlast, b_tid, b_tdest, b_user;
   logic [DW-1:0] b_tdata;
   logic [2:0]    b_tkeep, b_tstrb;

   bcci_axis_frame_source #(.AXIS_DATA_WIDTH(DW), .SRC_IMG_WIDTH(4), .SRC_IMG_HEIGHT(2),
                            .MEM_ADDR_WIDTH(20)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .start(a_start), .busy(a_busy), .done(a_done),
      .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
      .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready), .m_axis_tdata(a_tdata),
      .m_axis_tkeep(a_tkeep), .m_axis_tstrb(a_tstrb), .m_axis_tlast(a_tlast),
      .m_axis_tid(a_tid), .m_axis_tdest(a_tdest), .m_axis_user(a_user));

   bcci_axis_frame_source #(.AXIS_DATA_WIDTH(DW), .SRC_IMG_WIDTH(1), .SRC_IMG_HEIGHT(3),
                            .MEM_ADDR_WIDTH(2)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
      .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready), .m_axis_tdata(b_tdata),
      .m_axis_tkeep(b_tkeep), .m_axis_tstrb(b_tstrb), .m_axis_tlast(b_tlast),
      .m_axis_tid(b_tid), .m_axis_tdest(b_tdest), .m_axis_user(b_user));

   // Frame memories: memory[i] = i, one cycle read latency
   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= DW'(a_rd_addr);
      if (b_rd_en) b_rd_data <= DW'(b_rd_addr);
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   beat_t a_exp_q[$];
   beat_t b_exp_q[$];
   int    a_beats = 0;
   int    a_done_cnt = 0;
   int    b_beats = 0;

   // Hand-computed tags for the 4x2 frame: bit i is beat i
   localparam logic [7:0] A_LAST = 8'b1000_1000;
   localparam logic [7:0] A_USER = 8'b0000_0001;
   logic [7:0] a_last_tbl;
   logic [7:0] a_user_tbl;

   task automatic push_frame_a();
      a_last_tbl = A_LAST;
      a_user_tbl = A_USER;
      for (int i = 0; i < 8; i++)
         a_exp_q.push_back('{data: DW'(i), last: a_last_tbl[i], user: a_user_tbl[i]});
   endtask

   // Monitor A: scoreboard, payload stability under backpressure, read range, done count
   initial begin
      logic          stall_q;
      logic [DW-1:0] prev_data;
      beat_t         e;
      stall_q = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!a_rst_n) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               check_bit("a_stall_valid", a_tvalid, 1'b1);
               check_val("a_stall_data", 32'(a_tdata), 32'(prev_data));
            end
            if (a_tvalid && a_tready) begin
               if (a_exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL a_extra_beat: got data %0h, none expected", a_tdata);
               end else begin
                  e = a_exp_q.pop_front();
                  $display("A beat data=%0h last=%b user=%b", a_tdata, a_tlast, a_user);
                  check_val("a_tdata", 32'(a_tdata), 32'(e.data));
                  check_bit("a_tlast", a_tlast, e.last);
                  check_bit("a_user", a_user, e.user);
                  check_val("a_tkeep", 32'({a_tkeep, a_tstrb}), 32'h3f);
               end
               a_beats++;
            end
            if (a_rd_en) check_bit("a_rd_addr_in_range", a_rd_addr < 20'd8, 1'b1);
            if (a_done) a_done_cnt++;
            stall_q = a_tvalid && !a_tready;
            prev_data = a_tdata;
         end
      end
   end

   // Monitor B
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (b_rst_n && b_tvalid && b_tready) begin
            if (b_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_extra_beat: got data %0h, none expected", b_tdata);
            end else begin
               e = b_exp_q.pop_front();
               $display("B beat data=%0h last=%b user=%b", b_tdata, b_tlast, b_user);
               check_val("b_tdata", 32'(b_tdata), 32'(e.data));
               check_bit("b_tlast", b_tlast, e.last);
               check_bit("b_user", b_user, e.user);
            end
            b_beats++;
         end
         if (b_rst_n && b_rd_en) check_bit("b_rd_addr_in_range", b_rd_addr < 2'd3, 1'b1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle right after the edge that sampled start (cycle 0)
   task automatic pulse_start_a();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
   endtask

   initial begin
      int k;
      int d0;
      int n0;
      a_rst_n = 1'b0; a_start = 1'b0; a_tready = 1'b1;
      b_rst_n = 1'b0; b_start = 1'b0; b_tready = 1'b1;
      repeat (3) step();

      // Reset state
      check_val("rst_outputs", 32'({a_tvalid, a_tkeep, a_tstrb, a_busy, a_done, a_rd_en,
                                    a_tlast, a_user, a_tid, a_tdest}), 32'h0);
      check_val("rst_tdata", 32'(a_tdata), 32'h0);
      check_val("rst_addr", 32'(a_rd_addr), 32'h0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      step();

      // 1: full-rate frame
      push_frame_a();
      a_tready = 1'b1;
      pulse_start_a();
      check_bit("t1_busy_c0", a_busy, 1'b1);
      check_bit("t1_rden_c0", a_rd_en, 1'b1);
      check_bit("t1_valid_c0", a_tvalid, 1'b0);
      step();
      check_bit("t1_valid_c1", a_tvalid, 1'b0);
      step();
      check_bit("t1_valid_c2", a_tvalid, 1'b1);
      k = 2;
      while (!a_done && k < 60) begin step(); k++; end
      check_val("t1_done_cycle", k, 10);
      step();
      check_bit("t1_done_pulse", a_done, 1'b0);
      check_bit("t1_busy_after", a_busy, 1'b0);
      check_val("t1_queue_empty", a_exp_q.size(), 0);

      // 2: tready low for cycles 3..6
      push_frame_a();
      pulse_start_a();
      k = 0;
      while (!a_done && k < 60) begin
         a_tready = (k < 3 || k > 6);
         if (k >= 4 && k <= 6) check_bit("t2_rd_stalled", a_rd_en, 1'b0);
         step();
         k++;
      end
      check_val("t2_done_cycle", k, 14);
      a_tready = 1'b1;
      step();
      check_val("t2_queue_empty", a_exp_q.size(), 0);

      // 3: tready toggling every cycle
      push_frame_a();
      d0 = a_done_cnt;
      pulse_start_a();
      k = 0;
      while (!a_done && k < 80) begin
         a_tready = (k % 2 == 0);
         step();
         k++;
      end
      a_tready = 1'b1;
      repeat (5) step();
      check_val("t3_done_once", a_done_cnt - d0, 1);
      check_val("t3_queue_empty", a_exp_q.size(), 0);

      // 4: second start while busy is ignored
      push_frame_a();
      n0 = a_beats;
      pulse_start_a();
      k = 0;
      while (!a_done && k < 60) begin
         a_start = (k == 4);
         check_bit("t4_busy", a_busy, 1'b1);
         step();
         k++;
      end
      a_start = 1'b0;
      check_val("t4_done_cycle", k, 10);
      repeat (10) step();
      check_val("t4_beats", a_beats - n0, 8);
      check_bit("t4_no_restart", a_tvalid | a_busy, 1'b0);

      // 5: reset during beat 5, then a fresh frame
      push_frame_a();
      pulse_start_a();
      repeat (7) step();
      a_rst_n = 1'b0;
      a_tready = 1'b0;
      step();
      check_val("t5_rst_outputs", 32'({a_tvalid, a_tkeep, a_busy, a_done, a_rd_en}), 32'h0);
      a_exp_q.delete();
      a_rst_n = 1'b1;
      d0 = a_done_cnt;
      repeat (10) step();
      check_val("t5_no_done", a_done_cnt - d0, 0);
      check_bit("t5_idle_valid", a_tvalid, 1'b0);
      a_tready = 1'b1;
      push_frame_a();
      n0 = a_beats;
      pulse_start_a();
      k = 0;
      while (!a_done && k < 60) begin step(); k++; end
      check_val("t5_done_cycle", k, 10);
      check_val("t5_beats", a_beats - n0, 8);

      // 6: 1x3 frame, every beat ends a line
      b_exp_q.push_back('{data: 24'd0, last: 1'b1, user: 1'b1});
      b_exp_q.push_back('{data: 24'd1, last: 1'b1, user: 1'b0});
      b_exp_q.push_back('{data: 24'd2, last: 1'b1, user: 1'b0});
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      k = 0;
      while (!b_done && k < 40) begin step(); k++; end
      check_val("t6_done_cycle", k, 5);
      check_val("t6_beats", b_beats, 3);
      step();
      check_bit("t6_done_pulse", b_done, 1'b0);
      check_val("t6_queue_empty", b_exp_q.size(), 0);

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcci_axis_frame_source.md
Name: bcci_axis_frame_source

Overview:
AXI-Stream transmitter that feeds a source image into the upscaler's s_axis input. On a start pulse it reads SRC_IMG_WIDTH x SRC_IMG_HEIGHT pixels in raster order from a synchronous-read frame memory. It emits them as an AXI-Stream master, with m_axis_user marking the first pixel of the frame and m_axis_tlast marking the last pixel of each line. It is the stream-side counterpart to the upscaler's stream slave and is used both in the FPGA test harness and in the simulation environment.

Parameters:
AXIS_DATA_WIDTH, 24, pixel width (3 x 8-bit channels)
SRC_IMG_WIDTH, 960, pixels per line
SRC_IMG_HEIGHT, 540, lines per frame
MEM_ADDR_WIDTH, 20, frame memory word address width; must satisfy 2^MEM_ADDR_WIDTH >= SRC_IMG_WIDTH*SRC_IMG_HEIGHT

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle frame start request
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final beat handshake
mem_rd_en  out  1  frame memory read enable
mem_rd_addr  out  MEM_ADDR_WIDTH  linear pixel address
mem_rd_data  in  AXIS_DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  AXIS_DATA_WIDTH  pixel
m_axis_tkeep  out  AXIS_DATA_WIDTH/8  all ones when valid
m_axis_tstrb  out  AXIS_DATA_WIDTH/8  all ones when valid
m_axis_tlast  out  1  last pixel of a line
m_axis_tid  out  1  tied 0
m_axis_tdest  out  1  tied 0
m_axis_user  out  1  first pixel of frame (SOF)

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0. This includes tkeep/tstrb, busy, done and mem_rd_en. All counters, the FIFO and the FSM are cleared.
- Reset mid-frame: the frame is abandoned. tvalid is low after that edge. No done pulse is produced. A later start begins a fresh frame at address 0 with SOF.
- FSM states:
  - IDLE: on start go to FETCH and set busy.
  - FETCH: issue reads until all N = W*H reads have been issued, then go to DRAIN.
  - DRAIN: wait until the final beat handshake, then go to DONE.
  - DONE: done = 1 for one cycle, busy drops, return to IDLE.
- start is ignored while busy.
- Read issue rule (FETCH only): mem_rd_en = 1 when fifo_count + inflight < 2.
  - inflight is a 1-bit register equal to the previous cycle's mem_rd_en.
  - rd_addr starts at 0 and increments per issued read, up to N-1. No read is issued after N-1.
- The FIFO is 2 entries deep, holding {data, tlast, user}.
  - It is written with mem_rd_data the cycle after mem_rd_en.
  - The credit rule guarantees it can never overflow, so no data is ever dropped.
- Output side:
  - tvalid = FIFO non-empty; head entry drives tdata/tlast/user.
  - The head is popped on tvalid & tready.
  - Once asserted, tvalid and the payload stay stable until the handshake.
  - Simultaneous push and pop keeps the count unchanged.
- Tag generation at read issue:
  - A column counter (0..W-1) and a row counter (0..H-1) run alongside rd_addr. The column counter wraps to 0 and the row counter increments at W-1.
  - tlast = (col == W-1).
  - user = (rd_addr == 0).
- Throughput: with tready held high, one beat per cycle after a 2-cycle startup. The first tvalid is 2 cycles after the start edge: 1 cycle FSM, then 1 cycle memory latency.
- done is asserted on the cycle after the handshake of beat N-1. busy falls in that same cycle.
- tready may be low at any time, including on the first or last beat. In that case reads stall once the FIFO credit is exhausted, and rd_addr holds.

Test Plan:
- W=4, H=2, memory[i]=i, tready=1, start at cycle 0 → tvalid from cycle 2. Beats are 0..7 on consecutive cycles. user=1 on beat 0 only. tlast=1 on beats 3 and 7. done pulses on the cycle after beat 7.
- Same config, tready low for cycles 3-6 → data order 0..7 preserved with no loss or duplication. tdata is stable while tvalid & !tready. mem_rd_en is low while the FIFO holds 2 entries with 0 in flight.
- Same config, tready toggled 1/0 every cycle → 8 beats delivered in order. done pulses exactly once.
- start pulsed again at beat 2 → ignored. Exactly 8 beats are produced and busy stays high throughout.
- rst_n low for 1 cycle at beat 5 → tvalid is 0 after the edge and no done pulse occurs. A new start produces beat 0 with user=1 and tdata=0.
- W=1, H=3 → every beat has tlast=1. user=1 only on the first beat. done pulses after 3 beats.
